// File: rtl/mm_layer_ctrl.sv
// Layer-pass sequencer for matrix_multi + sigmoid_16: streams data/weight rows chunk by chunk,
// accumulates the partial-sum vector and registers the activated layer output.
module mm_layer_ctrl #(
  parameter int unsigned DATA_W     = 256,
  parameter int unsigned SUM_W      = 512,
  parameter int unsigned ROWS       = 16,
  parameter int unsigned NUM_CHUNKS = 7,
  localparam int unsigned CW        = $clog2(NUM_CHUNKS),
  localparam int unsigned WAW       = $clog2(NUM_CHUNKS * ROWS),
  localparam int unsigned IW        = $clog2(ROWS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              data_rd,
  output logic [CW-1:0]     data_addr,
  input  logic [DATA_W-1:0] data_rdata,
  output logic              weight_rd,
  output logic [WAW-1:0]    weight_addr,
  output logic              wbuf_we,
  output logic [IW-1:0]     wbuf_idx,
  output logic [DATA_W-1:0] data_buffer,
  output logic [SUM_W-1:0]  sum_input,
  input  logic [SUM_W-1:0]  sum_output,
  input  logic [DATA_W-1:0] sigmoid_in,
  output logic [DATA_W-1:0] result,
  output logic [CW-1:0]     chunk_idx
);

  // k runs 0..ROWS in FETCH and reaches ROWS+1 in DRAIN
  localparam int unsigned   KW        = $clog2(ROWS + 2);
  localparam logic [KW-1:0] KLast     = KW'(ROWS);
  localparam logic [CW-1:0] ChunkLast = CW'(NUM_CHUNKS - 1);
  localparam logic [WAW-1:0] RowsW    = WAW'(ROWS);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDrain,
    StAccum,
    StCapture,
    StDone
  } state_e;

  state_e             state_q, state_d;
  logic [KW-1:0]      k_q, k_d;
  logic [CW-1:0]      chunk_q, chunk_d;
  logic [DATA_W-1:0]  data_buf_q, data_buf_d;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic [DATA_W-1:0]  result_q, result_d;
  logic [WAW-1:0]     chunk_base;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort && state_q != StIdle) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:    if (start && !abort) state_d = StFetch;
        StFetch:   if (k_q == KLast) state_d = StDrain;
        StDrain:   state_d = StAccum;
        StAccum:   state_d = (chunk_q == ChunkLast) ? StCapture : StFetch;
        StCapture: state_d = StDone;
        StDone:    state_d = StIdle;
        default:   state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    chunk_base  = WAW'(chunk_q) * RowsW;
    busy        = (state_q != StIdle);
    done        = (state_q == StDone);
    data_rd     = 1'b0;
    data_addr   = '0;
    weight_rd   = 1'b0;
    weight_addr = '0;
    wbuf_we     = 1'b0;
    wbuf_idx    = '0;
    if (state_q == StFetch) begin
      if (k_q == '0) begin
        data_rd   = 1'b1;
        data_addr = chunk_q;
      end else begin
        weight_rd   = 1'b1;
        weight_addr = chunk_base + WAW'(k_q) - WAW'(1);
      end
    end
    // Weight memory returns one cycle late, so the bank write trails the read by one k step
    if ((state_q == StFetch && k_q >= KW'(2)) || state_q == StDrain) begin
      wbuf_we  = 1'b1;
      wbuf_idx = IW'(k_q - KW'(2));
    end
  end

  always_comb begin
    k_d        = '0;
    chunk_d    = chunk_q;
    data_buf_d = data_buf_q;
    sum_d      = sum_q;
    result_d   = result_q;
    if (abort && state_q != StIdle) begin
      chunk_d = '0;
      sum_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: if (start) chunk_d = '0;
        StFetch: begin
          k_d = k_q + KW'(1);
          if (k_q == KW'(1)) data_buf_d = data_rdata;
        end
        StAccum: begin
          sum_d = sum_output;
          if (chunk_q != ChunkLast) chunk_d = chunk_q + CW'(1);
        end
        StCapture: result_d = sigmoid_in;
        StDone: begin
          sum_d   = '0;
          chunk_d = '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q        <= '0;
      chunk_q    <= '0;
      data_buf_q <= '0;
      sum_q      <= '0;
      result_q   <= '0;
    end else begin
      k_q        <= k_d;
      chunk_q    <= chunk_d;
      data_buf_q <= data_buf_d;
      sum_q      <= sum_d;
      result_q   <= result_d;
    end
  end

  assign chunk_idx   = chunk_q;
  assign data_buffer = data_buf_q;
  assign sum_input   = sum_q;
  assign result      = result_q;

endmodule

// File: tb/tb_mm_layer_ctrl.sv
// Bench for mm_layer_ctrl: models data/weight memories, weight bank, matrix_multi and sigmoid,
// and scoreboards addresses, partial sums, results and done timing.
module tb_mm_layer_ctrl;

  logic         clk, rst_n, start, abort;
  logic         busy, done, data_rd, weight_rd, wbuf_we;
  logic [2:0]   data_addr, chunk_idx;
  logic [6:0]   weight_addr;
  logic [3:0]   wbuf_idx;
  logic [255:0] data_rdata, data_buffer, sigmoid_in, result;
  logic [511:0] sum_input, sum_output;

  logic [255:0] dmem [7];
  logic [255:0] wmem [112];
  logic [255:0] bank [16];
  logic [255:0] wmem_rdata;

  int     total, bad;
  longint cyc;
  int     dq[$], wq[$], bq[$];
  logic [511:0] sq[$];
  logic [255:0] rq[$];
  longint tq[$];
  logic [255:0] res1;
  bit     seen;

  mm_layer_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .busy(busy), .done(done),
    .data_rd(data_rd), .data_addr(data_addr), .data_rdata(data_rdata),
    .weight_rd(weight_rd), .weight_addr(weight_addr), .wbuf_we(wbuf_we), .wbuf_idx(wbuf_idx),
    .data_buffer(data_buffer), .sum_input(sum_input), .sum_output(sum_output),
    .sigmoid_in(sigmoid_in), .result(result), .chunk_idx(chunk_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (data_rd) data_rdata <= dmem[data_addr];
    if (weight_rd) wmem_rdata <= wmem[weight_addr];
    if (wbuf_we) bank[wbuf_idx] <= wmem_rdata;
  end

  // matrix_multi stand-in: lane j += sum over bank rows of (weight lane & data lane)
  always_comb begin
    sum_output = sum_input;
    for (int j = 0; j < 16; j++)
      for (int r = 0; r < 16; r++)
        sum_output[32*j +: 32] = sum_output[32*j +: 32] +
                                 {16'h0, bank[r][16*j +: 16] & data_buffer[16*j +: 16]};
  end

  always_comb begin
    sigmoid_in = '0;
    for (int j = 0; j < 16; j++) sigmoid_in[16*j +: 16] = sum_input[32*j+8 +: 16] ^ 16'hA5A5;
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Closed form: chunk c adds sum(16c..16c+15) = 256c+120 per lane
  function automatic logic [511:0] exp_sum(input int c);
    logic [511:0] v;
    for (int j = 0; j < 16; j++) v[32*j +: 32] = 32'((c + 1) * (128 * c + 120));
    return v;
  endfunction

  function automatic logic [255:0] exp_res();
    logic [511:0] s;
    logic [255:0] r;
    s = exp_sum(6);
    for (int j = 0; j < 16; j++) r[16*j +: 16] = s[32*j+8 +: 16] ^ 16'hA5A5;
    return r;
  endfunction

  task automatic push_chunk(input int c, input int nw, input int nb);
    dq.push_back(c);
    for (int i = 0; i < nw; i++) wq.push_back(c * 16 + i);
    for (int i = 0; i < nb; i++) bq.push_back(i);
  endtask

  task automatic push_pass(input longint e0);
    for (int c = 0; c < 7; c++) begin
      push_chunk(c, 16, 16);
      sq.push_back(exp_sum(c));
    end
    tq.push_back(e0 + 135);
    rq.push_back(exp_res());
  endtask

  task automatic chk_zero_all(input string p);
    chk({p, "_busy"}, busy, 0);
    chk({p, "_done"}, done, 0);
    chk({p, "_data_rd"}, data_rd, 0);
    chk({p, "_weight_rd"}, weight_rd, 0);
    chk({p, "_wbuf_we"}, wbuf_we, 0);
    chk({p, "_data_addr"}, data_addr, 0);
    chk({p, "_weight_addr"}, weight_addr, 0);
    chk({p, "_wbuf_idx"}, wbuf_idx, 0);
    chk({p, "_chunk_idx"}, chunk_idx, 0);
    chk({p, "_data_buffer"}, data_buffer, 0);
    chk({p, "_sum_input"}, sum_input, 0);
    chk({p, "_result"}, result, 0);
  endtask

  task automatic chk_queues(input string p);
    chk({p, "_dq_left"}, dq.size(), 0);
    chk({p, "_wq_left"}, wq.size(), 0);
    chk({p, "_bq_left"}, bq.size(), 0);
    chk({p, "_sq_left"}, sq.size(), 0);
    chk({p, "_tq_left"}, tq.size(), 0);
  endtask

  task automatic wait_done(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    chk("done_within_budget", got, 1);
  endtask

  initial begin
    for (int i = 0; i < 7; i++) dmem[i] = '1;
    for (int r = 0; r < 112; r++)
      for (int j = 0; j < 16; j++) wmem[r][16*j +: 16] = 16'(r);
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    total = 0;
    bad   = 0;

    fork
      begin : monitor
        int  sum_arm;
        bit  prev_wrd;
        sum_arm  = 0;
        prev_wrd = 1'b0;
        forever begin
          @(negedge clk);
          if (sum_arm != 0) begin
            sum_arm--;
            if (sum_arm == 0) begin
              chk("sum_pending", sq.size() != 0, 1);
              if (sq.size() != 0) chk("sum_input", sum_input, sq.pop_front());
            end
          end
          if (data_rd || weight_rd) chk("one_strobe", data_rd & weight_rd, 0);
          if (data_rd) begin
            chk("data_rd_pending", dq.size() != 0, 1);
            if (dq.size() != 0) chk("data_addr", data_addr, dq.pop_front());
          end
          if (weight_rd) begin
            chk("weight_rd_pending", wq.size() != 0, 1);
            if (wq.size() != 0) chk("weight_addr", weight_addr, wq.pop_front());
          end
          if (wbuf_we) begin
            chk("wbuf_follows_read", prev_wrd, 1);
            chk("wbuf_pending", bq.size() != 0, 1);
            if (bq.size() != 0) chk("wbuf_idx", wbuf_idx, bq.pop_front());
            if (wbuf_idx == 4'd15) sum_arm = 2;
          end
          if (done) begin
            chk("done_expected", tq.size() != 0, 1);
            if (tq.size() != 0) begin
              chk("done_cycle", cyc + 1, tq.pop_front());
              chk("result", result, rq.pop_front());
            end
          end
          prev_wrd = weight_rd;
        end
      end
    join_none

    #3;
    chk_zero_all("rst");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Full pass, with ignored starts while busy and during DONE
    push_pass(cyc + 1);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (40) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(200, seen);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("idle_after_done", busy, 0);
    repeat (3) @(posedge clk);
    #1 chk("start_in_done_ignored", busy, 0);
    res1 = exp_res();
    chk("result_holds", result, res1);
    chk_queues("pass1");

    // Abort in ACCUM of chunk 5
    for (int c = 0; c < 6; c++) push_chunk(c, 16, 16);
    for (int c = 0; c < 5; c++) sq.push_back(exp_sum(c));
    sq.push_back('0);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (113) @(posedge clk);
    #1 chk("chunk_before_abort", chunk_idx, 5);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_sum", sum_input, 0);
    chk("abort_chunk", chunk_idx, 0);
    chk("abort_result_kept", result, res1);
    chk("abort_no_done", done, 0);
    repeat (30) @(posedge clk);
    #1 chk_queues("abort");

    // Asynchronous reset mid-FETCH of chunk 3 (k=5)
    for (int c = 0; c < 3; c++) begin
      push_chunk(c, 16, 16);
      sq.push_back(exp_sum(c));
    end
    push_chunk(3, 4, 3);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (62) @(posedge clk);
    #1 chk("chunk_before_reset", chunk_idx, 3);
    rst_n = 1'b0;
    #1 chk_zero_all("midrst");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (25) @(posedge clk);
    #1 chk("post_reset_idle", busy, 0);
    chk_queues("reset");

    // start held high: back-to-back passes, done 136 cycles apart
    push_pass(cyc + 1);
    push_pass(cyc + 1 + 136);
    start = 1'b1;
    wait_done(200, seen);
    repeat (2) @(posedge clk);
    #1 start = 1'b0;
    chk("second_pass_started", busy, 1);
    wait_done(200, seen);
    repeat (2) @(posedge clk);
    #1 chk("idle_after_second", busy, 0);
    chk_queues("b2b");

    // abort and start together in IDLE
    abort = 1'b1;
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 chk("abort_start_idle", busy, 0);
    end
    abort = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk_queues("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
